// File: rtl/uart_program_loader.sv
// uart_program_loader: boot-time loader between uart_rx and uart_tx.
// Parses a 4-byte little-endian word count N, assembles N little-endian
// 32-bit words into sequential instruction-memory writes, then returns one
// acknowledge byte and holds done. Framing errors or an oversize N abort
// into a sticky error state.
module uart_program_loader #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter logic [7:0]  ACK_BYTE   = 8'hAA
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [7:0]            rx_data,
   input  logic                  rx_ready,
   input  logic                  rx_ferr,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   input  logic                  tx_busy,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [2:0] {
      HDR      = 3'd0,
      DATA     = 3'd1,
      ACK_WAIT = 3'd2,
      ACK_SEND = 3'd3,
      DONE     = 3'd4,
      ERR      = 3'd5
   } state_t;

   // Largest legal word count: the whole memory.
   localparam logic [31:0]         CAPACITY = 32'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state;
   logic [1:0]            byte_cnt;
   logic [ADDR_WIDTH:0]   word_cnt;
   logic [ADDR_WIDTH:0]   n_words;
   logic [31:0]           shreg;
   logic                  busy_seen;

   // Bytes shift in from the top, so after four bytes byte k sits in [8k+7:8k].
   logic [31:0]           word_next;
   logic [ADDR_WIDTH:0]   word_cnt_inc;

   assign word_next    = {rx_data, shreg[31:8]};
   assign word_cnt_inc = word_cnt + CNT_ONE;

   // Loader FSM: byte assembly, header decode, memory writes and ACK handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= HDR;
         byte_cnt   <= 2'd0;
         word_cnt   <= '0;
         n_words    <= '0;
         shreg      <= 32'd0;
         busy_seen  <= 1'b0;
         tx_data    <= 8'd0;
         tx_start   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         imem_we  <= 1'b0;
         tx_start <= 1'b0;
         unique case (state)
            HDR, DATA: begin
               if (rx_ready) begin
                  if (rx_ferr) begin
                     // A corrupted byte is dropped and the load is abandoned;
                     // any partially assembled word is never written.
                     state <= ERR;
                     err   <= 1'b1;
                  end else begin
                     shreg    <= word_next;
                     byte_cnt <= byte_cnt + 2'd1;
                     if (byte_cnt == 2'd3) begin
                        if (state == HDR) begin
                           if (word_next > CAPACITY) begin
                              state <= ERR;
                              err   <= 1'b1;
                           end else if (word_next == 32'd0) begin
                              state <= ACK_WAIT;
                           end else begin
                              n_words <= word_next[ADDR_WIDTH:0];
                              state   <= DATA;
                           end
                        end else begin
                           imem_we    <= 1'b1;
                           imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                           imem_wdata <= word_next;
                           word_cnt   <= word_cnt_inc;
                           if (word_cnt_inc == n_words) begin
                              state <= ACK_WAIT;
                           end
                        end
                     end
                  end
               end
            end
            ACK_WAIT: begin
               if (!tx_busy) begin
                  tx_data   <= ACK_BYTE;
                  tx_start  <= 1'b1;
                  busy_seen <= 1'b0;
                  state     <= ACK_SEND;
               end
            end
            ACK_SEND: begin
               // tx_busy only rises the cycle after tx_start, so a low level
               // means "finished" only once a high level has been observed.
               if (tx_busy) begin
                  busy_seen <= 1'b1;
               end else if (busy_seen) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE, ERR: begin
               state <= state;
            end
            default: begin
               state <= ERR;
               err   <= 1'b1;
            end
         endcase
      end
   end

endmodule
